// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared UART TX encodings (FSM states, TX mux selects, line levels)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    TXS_STOP  = 2'd0,
    TXS_START = 2'd1,
    TXS_DATA  = 2'd2,
    TXS_PAR   = 2'd3
  } tx_sel_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
//------------------------------------------------------------------------------
// uart_tx_ctrl_if : producer / parity-calc / pad signals around the TX controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  par_bit;
  logic                  PAR_FLAG;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, par_bit,
    input  PAR_FLAG, TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, par_bit,
    output PAR_FLAG, TX_OUT, Busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
//------------------------------------------------------------------------------
// uart_tx_serializer : payload shift register and data-bit counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ser_en,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  primed_q, primed_d;

  // The first shift only moves bit 0 onto the line; counting starts with the
  // second, so cnt_q equals the index of the bit currently being sent.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (load) begin
      shift_d  = load_data;
      cnt_d    = '0;
      primed_d = 1'b0;
    end else if (ser_en) begin
      shift_d  = shift_q >> 1;
      primed_d = 1'b1;
      if (primed_q && (cnt_q != CW'(DATA_WIDTH - 1))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign ser_bit  = shift_q[0];
  assign ser_done = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
//------------------------------------------------------------------------------
// uart_tx_ctrl : UART TX frame sequencer (start / data / parity / stop)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  tx_state_e state_q, state_d;
  tx_sel_e   tx_sel;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      ser_load, ser_en, ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .load_data (bus.P_DATA),
    .ser_en    (ser_en),
    .ser_bit   (ser_bit),
    .ser_done  (ser_done)
  );

  // Next-state logic selects what the line carries in the *next* cycle, so
  // TX_OUT comes straight from a flop and always matches state_q.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    par_en_d = par_en_q;
    tx_sel   = TXS_STOP;
    ser_load = 1'b0;
    ser_en   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.Data_Valid) begin
          state_d  = START;
          busy_d   = 1'b1;
          par_en_d = bus.PAR_EN;
          ser_load = 1'b1;
          tx_sel   = TXS_START;
        end
      end
      START: begin
        state_d = DATA;
        tx_sel  = TXS_DATA;
        ser_en  = 1'b1;
      end
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_sel  = par_en_q ? TXS_PAR : TXS_STOP;
        end else begin
          tx_sel = TXS_DATA;
          ser_en = 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (tx_sel)
      TXS_START: tx_d = START_BIT;
      TXS_DATA:  tx_d = ser_bit;
      TXS_PAR:   tx_d = bus.par_bit;
      default:   tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_q     <= STOP_BIT;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
    end
  end

  // Parity calculator reloads only while idle, i.e. up to and including the accept edge.
  assign bus.PAR_FLAG = (state_q == IDLE);
  assign bus.TX_OUT   = tx_q;
  assign bus.Busy     = busy_q;

endmodule

`default_nettype wire
